ysyx_25020047_mem_arbiter: RTL and testbench

- Arbitrates between the instruction-fetch unit (IFU, read-only) and the load/store unit (LSU, read/write with byte mask). Both share a single memory port.
- Holds at most one outstanding memory transaction. Uses round-robin arbitration and per-requester valid/ready request handshakes.
- Returns a registered response pulse to the owning requester.
- A watchdog aborts memory transactions that never complete.

---
 rtl/ysyx_25020047_mem_arbiter_if.sv | 45 ++++
 rtl/ysyx_25020047_mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_ysyx_25020047_mem_arbiter.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_25020047_mem_arbiter_if.sv
// Request/response bundle between the IFU, the LSU, the shared memory port and the arbiter.
// The arbiter uses the slave view; the surrounding requesters and memory use the master view.
interface ysyx_25020047_mem_arbiter_if;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_addr;
  logic        ifu_resp_valid;
  logic [31:0] ifu_rdata;

  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic [31:0] lsu_addr;
  logic        lsu_wen;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic        lsu_resp_valid;
  logic [31:0] lsu_rdata;

  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;

  modport slave (
    input  ifu_req_valid, ifu_addr,
    output ifu_req_ready, ifu_resp_valid, ifu_rdata,
    input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    output lsu_req_ready, lsu_resp_valid, lsu_rdata,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    input  mem_req_ready, mem_resp_valid, mem_rdata
  );

  modport master (
    output ifu_req_valid, ifu_addr,
    input  ifu_req_ready, ifu_resp_valid, ifu_rdata,
    output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    input  lsu_req_ready, lsu_resp_valid, lsu_rdata,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    output mem_req_ready, mem_resp_valid, mem_rdata
  );
endinterface

// File: rtl/ysyx_25020047_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between IFU and LSU, one transaction in flight,
// with a watchdog that aborts transactions the memory never finishes.
module ysyx_25020047_mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
  input  logic                              clk,
  input  logic                              rst_n,
  ysyx_25020047_mem_arbiter_if.slave        bus,
  output logic                              busy,
  output logic                              timeout_err
);

  localparam int unsigned CNT_W =
      (TIMEOUT_CYCLES == 0) ? 1 : (($clog2(TIMEOUT_CYCLES + 1) < 1) ? 1
                                   : $clog2(TIMEOUT_CYCLES + 1));
  localparam logic [CNT_W-1:0] CNT_LAST =
      (TIMEOUT_CYCLES == 0) ? {CNT_W{1'b0}} : CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic             r_owner;
  logic             r_last_grant;
  logic [31:0]      r_addr;
  logic             r_wen;
  logic [31:0]      r_wdata;
  logic [3:0]       r_wmask;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ifu_resp;
  logic             r_lsu_resp;
  logic [31:0]      r_ifu_rdata;
  logic [31:0]      r_lsu_rdata;
  logic             r_timeout_err;

  logic w_idle;
  logic w_active;
  logic w_grant_ifu;
  logic w_grant_lsu;
  logic w_accept;
  logic w_done;
  logic w_timeout;
  logic w_finish;

  // LSU wins a tie unless it was the last one served, so it goes first after reset.
  assign w_grant_lsu = bus.lsu_req_valid && (!bus.ifu_req_valid || r_last_grant == OWN_IFU);
  assign w_grant_ifu = bus.ifu_req_valid && !w_grant_lsu;

  assign w_idle   = (r_state == S_IDLE);
  assign w_active = (r_state == S_REQ) || (r_state == S_WAIT);

  assign bus.ifu_req_ready = w_idle && w_grant_ifu;
  assign bus.lsu_req_ready = w_idle && w_grant_lsu;
  assign w_accept          = bus.ifu_req_ready || bus.lsu_req_ready;

  // A response in the same cycle as the watchdog expiry wins over the abort.
  assign w_done    = (r_state == S_WAIT) && bus.mem_resp_valid;
  assign w_timeout = (TIMEOUT_CYCLES != 0) && w_active && (r_cnt == CNT_LAST) && !w_done;
  assign w_finish  = w_done || w_timeout;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = S_REQ;
      S_REQ: begin
        if (w_timeout)              w_state_nxt = S_IDLE;
        else if (bus.mem_req_ready) w_state_nxt = S_WAIT;
      end
      S_WAIT: if (w_finish) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_owner       <= OWN_IFU;
      r_last_grant  <= OWN_IFU;
      r_addr        <= 32'h0;
      r_wen         <= 1'b0;
      r_wdata       <= 32'h0;
      r_wmask       <= 4'h0;
      r_cnt         <= {CNT_W{1'b0}};
      r_ifu_resp    <= 1'b0;
      r_lsu_resp    <= 1'b0;
      r_ifu_rdata   <= 32'h0;
      r_lsu_rdata   <= 32'h0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      if (w_accept) begin
        r_owner      <= bus.lsu_req_ready;
        r_last_grant <= bus.lsu_req_ready;
        if (bus.lsu_req_ready) begin
          r_addr  <= bus.lsu_addr;
          r_wen   <= bus.lsu_wen;
          r_wdata <= bus.lsu_wdata;
          r_wmask <= bus.lsu_wmask;
        end else begin
          r_addr  <= bus.ifu_addr;
          r_wen   <= 1'b0;
          r_wdata <= 32'h0;
          r_wmask <= 4'h0;
        end
      end

      if (w_accept)      r_cnt <= {CNT_W{1'b0}};
      else if (w_active) r_cnt <= r_cnt + CNT_W'(1);

      r_ifu_resp <= w_finish && (r_owner == OWN_IFU);
      r_lsu_resp <= w_finish && (r_owner == OWN_LSU);

      if (w_finish && r_owner == OWN_IFU) r_ifu_rdata <= w_done ? bus.mem_rdata : ERR_DATA;
      if (w_finish && r_owner == OWN_LSU) r_lsu_rdata <= w_done ? bus.mem_rdata : ERR_DATA;

      if (w_timeout) r_timeout_err <= 1'b1;
    end
  end

  // Memory request fields come only from the latched copy so they stay stable under stalls.
  assign bus.mem_req_valid = (r_state == S_REQ);
  assign bus.mem_addr      = r_addr;
  assign bus.mem_wen       = r_wen;
  assign bus.mem_wdata     = r_wdata;
  assign bus.mem_wmask     = r_wmask;

  assign bus.ifu_resp_valid = r_ifu_resp;
  assign bus.ifu_rdata      = r_ifu_rdata;
  assign bus.lsu_resp_valid = r_lsu_resp;
  assign bus.lsu_rdata      = r_lsu_rdata;

  assign busy        = !w_idle;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_ysyx_25020047_mem_arbiter.sv
// Directed bench for the IFU/LSU memory arbiter: latency, round-robin, stalls, watchdog,
// stray responses and reset in the middle of a transaction.
module tb_ysyx_25020047_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;
  logic timeout_err;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  // Memory model knobs, written by the main sequence between negedges.
  int          stall_left = 0;
  bit          mem_silent = 1'b0;
  bit          spur       = 1'b0;
  logic [31:0] mem_data   = 32'h0;
  bit          pend       = 1'b0;

  ysyx_25020047_mem_arbiter_if b ();

  ysyx_25020047_mem_arbiter #(
    .TIMEOUT_CYCLES (8),
    .ERR_DATA       (32'hDEADBEEF)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (b),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  initial forever #5 clk = ~clk;

  // Zero-wait memory unless stalled; answers one cycle after accepting a request.
  initial begin
    b.mem_req_ready  = 1'b0;
    b.mem_resp_valid = 1'b0;
    b.mem_rdata      = 32'h0;
    forever begin
      @(negedge clk);
      b.mem_resp_valid = 1'b0;
      if (pend) begin
        b.mem_resp_valid = !mem_silent;
        b.mem_rdata      = mem_data;
        pend             = 1'b0;
      end
      if (spur) begin
        b.mem_resp_valid = 1'b1;
        b.mem_rdata      = 32'hBADC0DE0;
        spur             = 1'b0;
      end
      b.mem_req_ready = 1'b0;
      if (b.mem_req_valid) begin
        if (stall_left > 0) stall_left--;
        else begin
          b.mem_req_ready = 1'b1;
          pend            = 1'b1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Advance until the chosen response pulse shows up, bounded at 40 cycles.
  task automatic wait_resp(input bit is_lsu, output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!(is_lsu ? b.lsu_resp_valid : b.ifu_resp_valid) && lat < 40);
  endtask

  int lat;

  initial begin
    rst_n           = 1'b0;
    b.ifu_req_valid = 1'b0;
    b.ifu_addr      = 32'h0;
    b.lsu_req_valid = 1'b0;
    b.lsu_addr      = 32'h0;
    b.lsu_wen       = 1'b0;
    b.lsu_wdata     = 32'h0;
    b.lsu_wmask     = 4'h0;
    repeat (2) tick();

    check("rst_mem_req_valid", b.mem_req_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_ifu_resp", b.ifu_resp_valid, 0);
    check("rst_lsu_resp", b.lsu_resp_valid, 0);
    check("rst_mem_addr", b.mem_addr, 32'h0);
    rst_n = 1'b1;
    tick();

    // IFU alone, zero-wait memory.
    b.ifu_req_valid = 1'b1;
    b.ifu_addr      = 32'h80000000;
    mem_data        = 32'h00000413;
    #1;
    check("t1_ifu_ready", b.ifu_req_ready, 1);
    check("t1_lsu_ready", b.lsu_req_ready, 0);
    tick();
    b.ifu_req_valid = 1'b0;
    check("t1_mem_req_valid", b.mem_req_valid, 1);
    check("t1_mem_addr", b.mem_addr, 32'h80000000);
    check("t1_mem_wen", b.mem_wen, 0);
    check("t1_busy", busy, 1);
    wait_resp(1'b0, lat);
    check("t1_latency", lat + 1, 3);
    check("t1_ifu_rdata", b.ifu_rdata, 32'h00000413);
    check("t1_lsu_resp_quiet", b.lsu_resp_valid, 0);
    check("t1_idle_busy", busy, 0);

    // Both valid: LSU store wins the tie first.
    b.ifu_req_valid = 1'b1;
    b.ifu_addr      = 32'h80000004;
    b.lsu_req_valid = 1'b1;
    b.lsu_addr      = 32'h80000101;
    b.lsu_wen       = 1'b1;
    b.lsu_wdata     = 32'h0000AB00;
    b.lsu_wmask     = 4'h2;
    mem_data        = 32'h0;
    #1;
    check("t2_lsu_ready", b.lsu_req_ready, 1);
    check("t2_ifu_ready", b.ifu_req_ready, 0);
    tick();
    b.lsu_req_valid = 1'b0;
    check("t2_mem_addr", b.mem_addr, 32'h80000101);
    check("t2_mem_wen", b.mem_wen, 1);
    check("t2_mem_wdata", b.mem_wdata, 32'h0000AB00);
    check("t2_mem_wmask", b.mem_wmask, 32'h2);
    check("t2_ifu_held", b.ifu_req_ready, 0);
    wait_resp(1'b1, lat);
    check("t2_latency", lat + 1, 3);
    // Next grant lands in the same cycle as the response pulse; IFU's turn now.
    b.lsu_req_valid = 1'b1;
    b.lsu_addr      = 32'h80000200;
    b.lsu_wen       = 1'b0;
    b.lsu_wdata     = 32'h12345678;
    b.lsu_wmask     = 4'hF;
    mem_data        = 32'h11112222;
    #1;
    check("t2_ifu_ready_rr", b.ifu_req_ready, 1);
    check("t2_lsu_ready_rr", b.lsu_req_ready, 0);
    tick();
    b.ifu_req_valid = 1'b0;
    check("t2_ifu_mem_addr", b.mem_addr, 32'h80000004);
    check("t2_ifu_mem_wmask", b.mem_wmask, 32'h0);
    check("t2_ifu_mem_wen", b.mem_wen, 0);
    wait_resp(1'b0, lat);
    check("t2_ifu_latency", lat + 1, 3);
    check("t2_ifu_rdata", b.ifu_rdata, 32'h11112222);
    b.ifu_req_valid = 1'b1;
    #1;
    check("t2_lsu_again", b.lsu_req_ready, 1);
    check("t2_ifu_waits", b.ifu_req_ready, 0);

    // The LSU load just granted gets a 5-cycle memory stall.
    stall_left = 5;
    mem_data   = 32'hCAFEF00D;
    tick();
    b.lsu_req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("t3_mem_req_valid", b.mem_req_valid, 1);
      check("t3_mem_addr", b.mem_addr, 32'h80000200);
      check("t3_mem_wdata", b.mem_wdata, 32'h12345678);
      check("t3_ifu_ready", b.ifu_req_ready, 0);
      check("t3_lsu_ready", b.lsu_req_ready, 0);
      check("t3_busy", busy, 1);
      tick();
    end
    b.ifu_req_valid = 1'b0;
    wait_resp(1'b1, lat);
    check("t3_lsu_rdata", b.lsu_rdata, 32'hCAFEF00D);
    check("t3_no_error", timeout_err, 0);
    tick();

    // Memory accepts an LSU load but never answers: abort after 8 REQ+WAIT cycles.
    mem_silent      = 1'b1;
    b.lsu_req_valid = 1'b1;
    b.lsu_addr      = 32'h80000300;
    b.lsu_wen       = 1'b0;
    #1;
    check("t4_lsu_ready", b.lsu_req_ready, 1);
    tick();
    b.lsu_req_valid = 1'b0;
    wait_resp(1'b1, lat);
    // Accept at T, REQ/WAIT occupy T+1..T+8, pulse at T+9.
    check("t4_latency", lat + 1, 9);
    check("t4_lsu_rdata", b.lsu_rdata, 32'hDEADBEEF);
    check("t4_timeout_err", timeout_err, 1);
    check("t4_busy", busy, 0);
    check("t4_ifu_quiet", b.ifu_resp_valid, 0);
    mem_silent = 1'b0;
    tick();

    b.ifu_req_valid = 1'b1;
    b.ifu_addr      = 32'h80000008;
    mem_data        = 32'h00100073;
    tick();
    b.ifu_req_valid = 1'b0;
    wait_resp(1'b0, lat);
    check("t4_ifu_latency", lat + 1, 3);
    check("t4_ifu_rdata", b.ifu_rdata, 32'h00100073);
    check("t4_err_sticky", timeout_err, 1);

    // Stray memory response while idle must not produce a pulse.
    spur = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_ifu_resp", b.ifu_resp_valid, 0);
      check("t5_lsu_resp", b.lsu_resp_valid, 0);
      check("t5_busy", busy, 0);
    end
    check("t5_ifu_rdata_held", b.ifu_rdata, 32'h00100073);

    // Reset while waiting on the memory.
    mem_silent      = 1'b1;
    b.ifu_req_valid = 1'b1;
    b.ifu_addr      = 32'h8000000C;
    tick();
    b.ifu_req_valid = 1'b0;
    tick();
    check("t6_in_wait", busy, 1);
    rst_n = 1'b0;
    #1;
    check("t6_mem_req_valid", b.mem_req_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_ifu_resp", b.ifu_resp_valid, 0);
    check("t6_lsu_resp", b.lsu_resp_valid, 0);
    check("t6_err_cleared", timeout_err, 0);
    tick();
    tick();
    check("t6_no_pulse", b.ifu_resp_valid, 0);
    mem_silent = 1'b0;
    rst_n      = 1'b1;
    tick();

    b.ifu_req_valid = 1'b1;
    b.ifu_addr      = 32'h80000010;
    mem_data        = 32'h00A00093;
    #1;
    check("t6_ifu_ready", b.ifu_req_ready, 1);
    tick();
    b.ifu_req_valid = 1'b0;
    check("t6_mem_addr", b.mem_addr, 32'h80000010);
    wait_resp(1'b0, lat);
    check("t6_latency", lat + 1, 3);
    check("t6_ifu_rdata", b.ifu_rdata, 32'h00A00093);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
